// File: rtl/instr_pkg.sv
// Shared instruction-word definitions for the fetch/decode boundary.
// Field positions follow the fixed 32-bit encoding.
package instr_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_WIDTH = 64;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t              instr;
    logic [PC_WIDTH-1:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational slicer from an instruction word to its decode fields.
// No sign extension here; decode owns that.
module instr_fields
  import instr_pkg::*;
(
  input  instr_t      instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm
);

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_queue.sv
// Show-ahead instruction FIFO between fetch and decode, each entry tagged
// with its fetch PC. Flush empties the queue and drops that cycle's traffic.
module instr_queue
  import instr_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [15:0]                out_imm,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  entry_t          head;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high and flush is low; in_ready never looks at out_ready, so a full queue
  // refuses pushes even while it is being popped.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
    end
  end

  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  instr_fields u_fields (
    .instr  (out_instr),
    .opcode (out_opcode),
    .rs     (out_rs),
    .rt     (out_rt),
    .imm    (out_imm)
  );

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
Parametrised instruction buffer that replaces the single-entry instruction register between fetch and decode. It stores up to DEPTH instruction words, each tagged with its fetch PC, in a show-ahead FIFO. Fetch pushes and decode pops through valid/ready handshakes. A flush input discards all queued entries on a branch or exception. The head entry is presented together with pre-sliced decode fields.

Parameters:
DEPTH, 4, number of entries; must be a power of two and at least 2
PC_WIDTH, 64, width of the PC tag stored with each instruction
INSTR_WIDTH, 32, instruction word width; fixed at 32 because the field slices assume it

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  discard all entries; has priority over push
in_valid  input  1  fetch offers an instruction
in_ready  output  1  queue can accept an entry this cycle
in_instr  input  INSTR_WIDTH  instruction word to push
in_pc  input  PC_WIDTH  PC of in_instr
out_valid  output  1  head entry is valid
out_ready  input  1  decode consumes the head entry this cycle
out_instr  output  INSTR_WIDTH  head instruction (instr_all equivalent)
out_pc  output  PC_WIDTH  head PC
out_opcode  output  6  head instruction [31:26]
out_rs  output  5  head instruction [25:21]
out_rt  output  5  head instruction [20:16]
out_imm  output  16  head instruction [15:0]
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset: synchronous to clk and active-high. It clears rd_ptr, wr_ptr and count to 0. After reset, out_valid=0, in_ready=1, and all out_* data outputs are 0. Storage contents are don't-care.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so there is no push into a full queue even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- Head data outputs are combinational reads of entry[rd_ptr]. While out_valid=0 they are masked to 0.
- Latency: an entry pushed at edge N is visible at the head after edge N. There is no bypass: an empty queue shows out_valid=1 one cycle after the push cycle.
- Ordering is strict FIFO.
- Pointers wrap modulo DEPTH using natural $clog2(DEPTH)-bit overflow. count is the authoritative full/empty indicator.
- Count updates per cycle:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, and both pointers advance
- Stall: while out_valid=1 and out_ready=0, the head outputs stay stable regardless of pushes.
- Flush: at the next edge, rd_ptr=wr_ptr=0 and count=0. Any push or pop offered in the flush cycle is dropped, so fetch must re-present after flush. out_valid is 0 the cycle after flush.
- Reset mid-operation: same effect as flush. It overrides every other input in that cycle.
- Field slices are fixed bit ranges of out_instr. There is no sign extension; decode owns that.

Decomposition:
- Package instr_pkg holds:
  - field position constants OPC_MSB/LSB, RS_MSB/LSB, RT_MSB/LSB, IMM_MSB/LSB
  - typedef instr_t (logic [31:0])
  - typedef struct iq_entry_t {instr_t instr; logic [PC_WIDTH-1:0] pc;}, with PC_WIDTH taken from a package localparam default
- One sub-module is natural: instr_fields, a purely combinational slicer from instr_t to opcode/rs/rt/imm. Decode reuses it.
- The storage array and pointers stay in instr_queue.

Test Plan:
1. Reset and wait 2 cycles -> out_valid=0, in_ready=1, count=0, out_instr=0, out_rs=0, out_imm=0.
2. Push 0x8C430010 with pc=0x1000, out_ready=0 -> the next cycle shows out_valid=1, out_opcode=0x23, out_rs=2, out_rt=3, out_imm=0x0010, out_pc=0x1000, and the outputs hold across 3 stall cycles.
3. Push 4 entries (pc 0x0, 0x4, 0x8, 0xC) with out_ready=0 -> count=4 and in_ready=0. A 5th in_valid is not accepted. Then pop all 4 -> PCs appear in order 0x0, 0x4, 0x8, 0xC and count=0.
4. Hold count=2 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, the pointers wrap past DEPTH, and the output PC sequence is in order with no loss.
5. Queue holds 3 entries; assert flush together with in_valid=1 and out_ready=1 -> the next cycle shows count=0 and out_valid=0. Neither the flush-cycle push nor the pop takes effect, and a subsequent push appears after 1 cycle.
6. Assert reset while count=3 and push is active -> the next cycle matches the post-reset state in scenario 1.
